// File: rtl/nibble_add_pkg.sv
// Shared types and constants for the nibble-serial add/sub datapath.
package nibble_add_pkg;

    localparam int unsigned NIB_W = 4;

    typedef enum logic [1:0] {IDLE, RUN, DONE} nsas_state_t;

endpackage

// File: rtl/ripple_carry_adder.sv
// 4-bit ripple-carry adder: one full-adder cell per bit, carry rippling LSB to MSB.
module ripple_carry_adder
    import nibble_add_pkg::*;
(
    input  logic [NIB_W-1:0] a,
    input  logic [NIB_W-1:0] b,
    input  logic             cin,
    output logic [NIB_W-1:0] sum,
    output logic             cout
);

    logic [NIB_W:0] c;

    always_comb begin
        c    = '0;
        sum  = '0;
        c[0] = cin;
        for (int i = 0; i < NIB_W; i++) begin
            sum[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

    assign cout = c[NIB_W];

endmodule

// File: rtl/nibble_serial_add_sub.sv
// Multi-cycle WIDTH-bit add/subtract, one nibble per clock through ripple_carry_adder.
// Define NSAS_BACK_TO_BACK_EN to allow a new accept in the same cycle as the result handshake.
module nibble_serial_add_sub
    import nibble_add_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow
);

    localparam int unsigned NIB   = WIDTH / NIB_W;
    localparam int unsigned CNT_W = (NIB > 1) ? $clog2(NIB) : 1;

    if ((WIDTH % NIB_W) != 0 || WIDTH < NIB_W) begin : g_bad_width
        $error("nibble_serial_add_sub: WIDTH must be a multiple of 4 and >= 4");
    end

    nsas_state_t      state, state_d;
    logic [WIDTH-1:0] a_sh, a_sh_d, b_sh, b_sh_d, result_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic             cy, cy_d, a_msb, a_msb_d, b_msb, b_msb_d;
    logic             out_valid_d, carry_out_d, overflow_d;
    logic [NIB_W-1:0] nib_sum;
    logic             nib_cout;

    ripple_carry_adder u_rca (
        .a    (a_sh[NIB_W-1:0]),
        .b    (b_sh[NIB_W-1:0]),
        .cin  (cy),
        .sum  (nib_sum),
        .cout (nib_cout)
    );

    // Accept window: IDLE always; DONE only when the result leaves this same cycle.
    always_comb begin
        in_ready = 1'b0;
        if (!rst) begin
            if (state == IDLE) begin
                in_ready = 1'b1;
            end
`ifdef NSAS_BACK_TO_BACK_EN
            else if (state == DONE) begin
                in_ready = out_ready;
            end
`endif
        end
    end

    always_comb begin
        state_d     = state;
        a_sh_d      = a_sh;
        b_sh_d      = b_sh;
        cy_d        = cy;
        cnt_d       = cnt;
        a_msb_d     = a_msb;
        b_msb_d     = b_msb;
        result_d    = result;
        out_valid_d = out_valid;
        carry_out_d = carry_out;
        overflow_d  = overflow;

        case (state)
            RUN: begin
                result_d = (result >> NIB_W) | (WIDTH'(nib_sum) << (WIDTH - NIB_W));
                a_sh_d   = a_sh >> NIB_W;
                b_sh_d   = b_sh >> NIB_W;
                cy_d     = nib_cout;
                cnt_d    = cnt + CNT_W'(1);
                if (cnt == CNT_W'(NIB - 1)) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                    carry_out_d = nib_cout;
                    overflow_d  = (a_msb == b_msb) & (nib_sum[NIB_W-1] != a_msb);
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: ;
        endcase

        // Subtraction is A + ~B + 1: invert B here and seed the carry with sub.
        if (in_valid && in_ready) begin
            a_sh_d  = op_a;
            b_sh_d  = sub ? ~op_b : op_b;
            cy_d    = sub;
            cnt_d   = '0;
            a_msb_d = op_a[WIDTH-1];
            b_msb_d = sub ? ~op_b[WIDTH-1] : op_b[WIDTH-1];
            state_d = RUN;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            a_sh      <= '0;
            b_sh      <= '0;
            cy        <= 1'b0;
            cnt       <= '0;
            a_msb     <= 1'b0;
            b_msb     <= 1'b0;
            result    <= '0;
            out_valid <= 1'b0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            state     <= state_d;
            a_sh      <= a_sh_d;
            b_sh      <= b_sh_d;
            cy        <= cy_d;
            cnt       <= cnt_d;
            a_msb     <= a_msb_d;
            b_msb     <= b_msb_d;
            result    <= result_d;
            out_valid <= out_valid_d;
            carry_out <= carry_out_d;
            overflow  <= overflow_d;
        end
    end

endmodule

// File: tb/tb_nibble_serial_add_sub.sv
// Bench for nibble_serial_add_sub (WIDTH=16); expected values come from integer arithmetic.
module tb_nibble_serial_add_sub;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, sub, out_valid, out_ready, carry_out, overflow;
    logic [15:0] op_a, op_b, result;

    int total = 0, passed = 0, failed = 0;
    int cyc = 0, acc_n = 0, hs_n = 0;
    bit log_en = 1'b0;
    int          acc_cyc[$];
    logic [15:0] qa[$], qb[$], qr[$];
    logic        qs[$], qc[$], qv[$];

    nibble_serial_add_sub #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry_out (carry_out),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    // Handshake monitor
    always @(posedge clk) begin
        if (in_valid && in_ready) begin
            acc_n++;
            if (log_en) begin
                acc_cyc.push_back(cyc);
                qa.push_back(op_a); qb.push_back(op_b); qs.push_back(sub);
            end
        end
        if (out_valid && out_ready) begin
            hs_n++;
            if (log_en) begin
                qr.push_back(result); qc.push_back(carry_out); qv.push_back(overflow);
            end
        end
        cyc++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain unsigned/signed integer arithmetic
    task automatic model(input logic [15:0] a, input logic [15:0] b, input logic s,
                         output logic [15:0] r, output logic c, output logic v);
        int ua, ub, sa, sb, full, sr;
        ua = int'(a); ub = int'(b);
        sa = int'($signed(a)); sb = int'($signed(b));
        if (s) begin
            full = ua - ub; c = (ua >= ub); sr = sa - sb;
        end else begin
            full = ua + ub; c = (full > 65535); sr = sa + sb;
        end
        r = 16'(full);
        v = (sr > 32767) || (sr < -32768);
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!in_ready && n < 50) begin step(); n++; end
        check("in_ready_wait", 32'(in_ready), 32'd1);
    endtask

    // One full operation with a prompt consumer; latency counts the accept edge as edge 1.
    task automatic do_op(input string tag, input logic [15:0] a, input logic [15:0] b, input logic s);
        logic [15:0] er; logic ec, ev; int n;
        model(a, b, s, er, ec, ev);
        wait_ready();
        op_a = a; op_b = b; sub = s; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 30) begin step(); n++; end
        check({tag, "_latency"}, 32'(n), 32'd5);
        check({tag, "_result"}, 32'(result), 32'(er));
        check({tag, "_carry"}, 32'(carry_out), 32'(ec));
        check({tag, "_ovf"}, 32'(overflow), 32'(ev));
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check({tag, "_ov_drop"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        logic [15:0] held, ra, rb;
        int acc0, hs0, n, exp_gap;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op_a = '0; op_b = '0; sub = 1'b0;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_flags", {30'd0, carry_out, overflow}, 32'd0);
        step(); step();
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);

        do_op("add_basic", 16'h1234, 16'h0FCD, 1'b0);
        check("add_basic_value", 32'(result), 32'h2201);
        do_op("add_wrap", 16'hFFFF, 16'h0001, 1'b0);
        check("add_wrap_value", {15'd0, carry_out, result}, 32'h10000);
        do_op("add_ovf", 16'h7FFF, 16'h0001, 1'b0);
        check("add_ovf_value", {14'd0, overflow, carry_out, result}, 32'h28000);
        do_op("sub_borrow", 16'h0005, 16'h0007, 1'b1);
        check("sub_borrow_value", {14'd0, overflow, carry_out, result}, 32'h0FFFE);
        do_op("sub_ovf", 16'h8000, 16'h0001, 1'b1);
        check("sub_ovf_value", {14'd0, overflow, carry_out, result}, 32'h37FFF);

        for (int i = 0; i < 6; i++) begin
            do_op("rand", 16'($urandom), 16'($urandom), 1'($urandom));
        end

        // Backpressure: result held, no accepts while the consumer stalls
        acc0 = acc_n; hs0 = hs_n;
        wait_ready();
        op_a = 16'hA5A5; op_b = 16'h1111; sub = 1'b1; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 30) begin step(); n++; end
        check("bp_out_valid", 32'(out_valid), 32'd1);
        held = result;
        check("bp_value", 32'(held), 32'h9494);
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'(i % 2 == 0);
            op_a = 16'($urandom); op_b = 16'($urandom);
            #1;
            check("bp_in_ready", 32'(in_ready), 32'd0);
            step();
            check("bp_hold", {14'd0, out_valid, carry_out, result}, {14'd0, 1'b1, 1'b1, held});
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        step(); step(); step();
        check("bp_no_extra_accept", 32'(acc_n - acc0), 32'd1);
        check("bp_one_handshake", 32'(hs_n - hs0), 32'd1);
        check("bp_idle_ready", 32'(in_ready), 32'd1);

        // Reset in the second RUN cycle aborts the op
        hs0 = hs_n;
        op_a = 16'h4444; op_b = 16'h3333; sub = 1'b0; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        rst = 1'b1;
        #1;
        check("abort_result", 32'(result), 32'd0);
        check("abort_outs", {29'd0, out_valid, carry_out, overflow}, 32'd0);
        check("abort_in_ready", 32'(in_ready), 32'd0);
        step(); step();
        rst = 1'b0;
        #1;
        check("abort_ready_after", 32'(in_ready), 32'd1);
        n = 0;
        for (int i = 0; i < 8; i++) begin step(); n += int'(out_valid); end
        check("abort_no_out_valid", 32'(n), 32'd0);
        check("abort_no_handshake", 32'(hs_n - hs0), 32'd0);
        do_op("after_abort", 16'h0001, 16'h0001, 1'b0);
        check("after_abort_value", 32'(result), 32'h0002);

        // Streaming: continuous in_valid/out_ready for 4 ops
`ifdef NSAS_BACK_TO_BACK_EN
        exp_gap = 5;
`else
        exp_gap = 6;
`endif
        log_en = 1'b1;
        acc0 = acc_n;
        op_a = 16'($urandom); op_b = 16'($urandom); sub = 1'($urandom);
        in_valid = 1'b1; out_ready = 1'b1;
        n = 0;
        while (qr.size() < 4 && n < 200) begin
            step(); n++;
            if (acc_n != acc0) begin
                acc0 = acc_n;
                op_a = 16'($urandom); op_b = 16'($urandom); sub = 1'($urandom);
            end
            if (qa.size() >= 4) in_valid = 1'b0;
        end
        in_valid = 1'b0; out_ready = 1'b0;
        log_en = 1'b0;
        check("stream_accepts", 32'(qa.size()), 32'd4);
        check("stream_results", 32'(qr.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            logic [15:0] er; logic ec, ev;
            if (i < qa.size() && i < qr.size()) begin
                model(qa[i], qb[i], qs[i], er, ec, ev);
                check("stream_result", 32'(qr[i]), 32'(er));
                check("stream_flags", {30'd0, qc[i], qv[i]}, {30'd0, ec, ev});
            end
            if (i > 0 && i < acc_cyc.size()) begin
                check("stream_gap", 32'(acc_cyc[i] - acc_cyc[i-1]), 32'(exp_gap));
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
